// File: rtl/ldm_agu_if.sv
// rtl/ldm_agu_if.sv - command capture and transfer handshake bundle for ldm_agu
// The upstream/memory side uses master; the sequencer uses slave.
interface ldm_agu_if;
   logic        start;
   logic [15:0] bits;
   logic [31:0] base;
   logic        up;
   logic        pre;
   logic        load;
   logic        wb_en;
   logic        busy;
   logic        valid;
   logic        ready;
   logic [3:0]  reg_idx;
   logic [31:0] addr;
   logic        is_load;
   logic        last;
   logic        wb_valid;
   logic [31:0] wb_value;

   modport master (
      output start, bits, base, up, pre, load, wb_en, ready,
      input  busy, valid, reg_idx, addr, is_load, last, wb_valid, wb_value
   );

   modport slave (
      input  start, bits, base, up, pre, load, wb_en, ready,
      output busy, valid, reg_idx, addr, is_load, last, wb_valid, wb_value
   );
endinterface

// File: rtl/ldm_agu.sv
// rtl/ldm_agu.sv - LDM/STM address sequencer: one word transfer per set register bit
// Registers go out in ascending order at ascending addresses, then the base writeback.
module ldm_agu (
   input  logic     clk,
   input  logic     rst_n,
   ldm_agu_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [15:0] list_q, list_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wb_value_q, wb_value_d;
   logic [3:0]  reg_idx_q, reg_idx_d;
   logic        is_load_q, is_load_d;
   logic        wb_en_q, wb_en_d;

   logic [31:0] span;
   logic [15:0] list_next;
   logic        one_left;
   logic        handshake;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
      return c;
   endfunction

   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
      return idx;
   endfunction

   always_comb begin
      span       = {25'd0, popcount16(bus.bits), 2'b00};
      // v & (v-1) drops the lowest set bit; zero result means at most one bit was set
      list_next  = list_q & (list_q - 16'd1);
      one_left   = (list_q != 16'd0) && (list_next == 16'd0);
      handshake  = (state_q == XFER) && bus.ready;

      state_d    = state_q;
      list_d     = list_q;
      addr_d     = addr_q;
      wb_value_d = wb_value_q;
      reg_idx_d  = reg_idx_q;
      is_load_d  = is_load_q;
      wb_en_d    = wb_en_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               list_d    = bus.bits;
               reg_idx_d = lowest_set(bus.bits);
               is_load_d = bus.load;
               wb_en_d   = bus.wb_en;
               case ({bus.up, bus.pre})
                  2'b10:   addr_d = bus.base;
                  2'b11:   addr_d = bus.base + 32'd4;
                  2'b00:   addr_d = bus.base - span + 32'd4;
                  default: addr_d = bus.base - span;
               endcase
               wb_value_d = bus.up ? (bus.base + span) : (bus.base - span);
               state_d    = (bus.bits == 16'd0) ? DONE : XFER;
            end
         end
         XFER: begin
            if (handshake) begin
               list_d    = list_next;
               reg_idx_d = lowest_set(list_next);
               addr_d    = addr_q + 32'd4;
               if (one_left) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         list_q     <= '0;
         addr_q     <= '0;
         wb_value_q <= '0;
         reg_idx_q  <= '0;
         is_load_q  <= 1'b0;
         wb_en_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         list_q     <= list_d;
         addr_q     <= addr_d;
         wb_value_q <= wb_value_d;
         reg_idx_q  <= reg_idx_d;
         is_load_q  <= is_load_d;
         wb_en_q    <= wb_en_d;
      end
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.valid    = (state_q == XFER);
   assign bus.last     = (state_q == XFER) && one_left;
   assign bus.wb_valid = (state_q == DONE) && wb_en_q;
   assign bus.reg_idx  = reg_idx_q;
   assign bus.addr     = addr_q;
   assign bus.is_load  = is_load_q;
   assign bus.wb_value = wb_value_q;
endmodule

// File: tb/tb_ldm_agu.sv
// tb/tb_ldm_agu.sv - randomized scoreboard bench for ldm_agu
module tb_ldm_agu;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ldm_agu_if bus ();
   ldm_agu dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   typedef struct packed {
      logic [3:0]  idx;
      logic [31:0] addr;
      logic        last;
      logic        ld;
   } xfer_t;

   xfer_t       exp_q[$];
   logic [31:0] wb_q[$];
   logic [31:0] cur_wb = '0;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every handshake and writeback against the scoreboard.
   logic        stall_p = 1'b0;
   logic [3:0]  idx_p   = '0;
   logic [31:0] addr_p  = '0;
   logic        last_p  = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_p <= 1'b0;
      end else begin
         if (stall_p)
            check("stall_hold", {27'd0, bus.valid, bus.reg_idx, bus.addr, bus.last},
                  {27'd0, 1'b1, idx_p, addr_p, last_p});
         if (bus.valid && bus.ready) begin
            if (exp_q.size() == 0) check("unexpected_xfer", 64'd1, 64'd0);
            else begin
               check("xfer", {26'd0, bus.reg_idx, bus.addr, bus.last, bus.is_load},
                     {26'd0, exp_q[0]});
               exp_q.delete(0);
            end
         end
         if (bus.wb_valid) begin
            if (wb_q.size() == 0) check("unexpected_wb", 64'd1, 64'd0);
            else begin
               check("wb_value", {32'd0, bus.wb_value}, {32'd0, wb_q[0]});
               wb_q.delete(0);
            end
         end
         if (bus.busy) check("wb_value_stable", {32'd0, bus.wb_value}, {32'd0, cur_wb});
         stall_p <= bus.valid && !bus.ready;
         idx_p   <= bus.reg_idx;
         addr_p  <= bus.addr;
         last_p  <= bus.last;
      end
   end

   // Reference model: the block occupies n consecutive words; lowest register at lowest word.
   task automatic push_model(input logic [15:0] b, input logic [31:0] bs,
                             input logic u, input logic p, input logic l, input logic w);
      int          n;
      int          k;
      logic [31:0] first;
      logic [31:0] top;
      n = $countones(b);
      if (u) begin
         first  = bs + (p ? 32'd4 : 32'd0);
         cur_wb = bs + 32'(4 * n);
      end else begin
         top    = bs - (p ? 32'd4 : 32'd0);
         first  = top - 32'(4 * (n - 1));
         cur_wb = bs - 32'(4 * n);
      end
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (b[i]) begin
            exp_q.push_back('{idx: 4'(i), addr: first + 32'(4 * k), last: (k == n - 1), ld: l});
            k++;
         end
      end
      if (w) wb_q.push_back(cur_wb);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},     {63'd0, bus.busy},     64'd0);
      check({tag, "_valid"},    {63'd0, bus.valid},    64'd0);
      check({tag, "_last"},     {63'd0, bus.last},     64'd0);
      check({tag, "_wb_valid"}, {63'd0, bus.wb_valid}, 64'd0);
      check({tag, "_outs"}, {27'd0, bus.reg_idx, bus.addr, bus.is_load},  64'd0);
      check({tag, "_wb_value"}, {32'd0, bus.wb_value}, 64'd0);
   endtask

   // rmode: 0 ready always high, 1 random ready, 2 ready low for first 3 XFER cycles
   task automatic run_cmd(input logic [15:0] b, input logic [31:0] bs, input logic u,
                          input logic p, input logic l, input logic w,
                          input int rmode, input bit extra);
      int n;
      int c;
      n = $countones(b);
      @(posedge clk); #1;
      bus.bits = b; bus.base = bs; bus.up = u; bus.pre = p; bus.load = l; bus.wb_en = w;
      bus.start = 1'b1;
      push_model(b, bs, u, p, l, w);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.bits = 16'($urandom); bus.base = $urandom; bus.up = 1'($urandom);
      bus.pre = 1'($urandom); bus.load = 1'($urandom); bus.wb_en = 1'($urandom);
      c = 1;
      check("first_busy",  {63'd0, bus.busy},  64'd1);
      check("first_valid", {63'd0, bus.valid}, {63'd0, (n > 0)});
      while (bus.busy && c < 300) begin
         case (rmode)
            0:       bus.ready = 1'b1;
            1:       bus.ready = 1'($urandom);
            default: bus.ready = (c > 3);
         endcase
         bus.start = (extra && c == 2);
         @(posedge clk); #1;
         c++;
      end
      bus.start = 1'b0;
      if (bus.busy) check("timeout", 64'd1, 64'd0);
      if (rmode == 0) check("cycles_to_idle", 64'(c), 64'(n + 2));
      else if (rmode == 2) check("cycles_to_idle", 64'(c), 64'(n + 2 + ((n > 0) ? 3 : 0)));
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      check("wb_q_drained",  64'(wb_q.size()),  64'd0);
   endtask

   initial begin
      bus.start = 1'b0; bus.bits = '0; bus.base = '0; bus.up = 1'b0; bus.pre = 1'b0;
      bus.load = 1'b0; bus.wb_en = 1'b0; bus.ready = 1'b0;
      #12;
      check_reset_vals("reset");
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset_vals("post_reset");

      run_cmd(16'h8421, 32'h1000, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
      run_cmd(16'hFFFF, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      run_cmd(16'h0003, 32'h0100, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b0);
      run_cmd(16'h0003, 32'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      run_cmd(16'h0000, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      run_cmd(16'h0000, 32'hCAFE_0000, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
      run_cmd(16'h8001, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      run_cmd(16'h0F0F, 32'h4000, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1);
      run_cmd(16'h4000, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1);

      // Reset while the second word of a full-list transfer is on the bus
      @(posedge clk); #1;
      bus.bits = 16'hFFFF; bus.base = 32'h2000; bus.up = 1'b0; bus.pre = 1'b1;
      bus.load = 1'b1; bus.wb_en = 1'b1; bus.start = 1'b1;
      push_model(16'hFFFF, 32'h2000, 1'b0, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.ready = 1'b1;
      @(posedge clk); #1;
      check("mid_second_idx", {60'd0, bus.reg_idx}, 64'd1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_reset");
      exp_q.delete();
      wb_q.delete();
      cur_wb = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      run_cmd(16'h00F0, 32'h3000, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         run_cmd(16'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1, bit'($urandom));
      end
      for (int t = 0; t < 10; t++) begin
         run_cmd(16'(1 << $urandom_range(15, 0)), $urandom, 1'($urandom), 1'($urandom),
                 1'($urandom), 1'b1, 0, 1'b1);
      end

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
